nios_keycode_fifo_pio: RTL and testbench
========================================

Name: nios_keycode_fifo_pio

Overview:
Parametrised successor to the single-register keycode PIO. It is an Avalon-MM slave on the Nios II bus. CPU writes to DATA are pushed into a DEPTH-entry FIFO and drained to fabric over a valid/ready stream, so bursts of keycodes are not lost when the consumer stalls. It also drives a legacy level output holding the last accepted word, and adds status, control and interrupt registers.

Parameters:
DATA_W, 8, keycode/word width (1..32)
DEPTH, 8, FIFO entries; power of two, 2..256
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero-wait-state, combinational from address
out_port  out  DATA_W  last word accepted into FIFO (legacy level output)
key_data  out  DATA_W  FIFO head
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts head
irq  out  1  level interrupt to Nios

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset), sampled on posedge clk only.
- Register map, bus write = chipselect & ~write_n:
  - 0 DATA: W pushes writedata[DATA_W-1:0]. R returns out_port zero-extended.
  - 1 STATUS (R): [CNT_W-1:0] count, [16] empty, [17] full, [18] overflow (sticky). W: writedata[18]=1 clears overflow.
  - 2 CONTROL (R/W): [0] enable, [1] flush. Flush is write-only and self-clearing; it always reads 0.
  - 3 IRQMASK (R/W): [0] empty_ie, [1] overflow_ie.
  - Unused read bits return 0.
- Reset values:
  - count=0, rd/wr pointers=0, out_port=0, overflow=0, enable=1, IRQMASK=0.
  - key_valid=0, irq=0, key_data=0 (storage array not reset; key_data is masked to 0 when empty).
- Push = write to DATA & enable. Pop = key_valid & key_ready.
- Latency: a word pushed in cycle N appears on key_valid/key_data in cycle N+1.
- Push when not full: store at wr_ptr, wr_ptr++ (wraps modulo DEPTH), count++, out_port <= word.
- Push when full and no pop in the same cycle: word dropped, count unchanged, out_port unchanged, overflow <= 1.
- Push and pop in the same cycle:
  - Not empty: both occur, count unchanged. This includes the full case, where no overflow is flagged.
  - Empty: pop cannot occur because key_valid=0; push proceeds normally.
- Write to DATA with enable=0: ignored, no overflow flagged.
- Flush (CONTROL write with bit1=1): next cycle count=0 and both pointers=0. A pop in the flush cycle counts as consumed. out_port and overflow are unchanged. The enable bit from the same write still takes effect.
- Overflow: set-on-drop, cleared by STATUS write with bit18=1. If set and clear occur in the same cycle, set wins.
- irq = (empty_ie & empty) | (overflow_ie & overflow), registered, so it has 1-cycle latency from the state change.
- count never exceeds DEPTH and never underflows.
- Pointers are $clog2(DEPTH) bits; full is count==DEPTH, empty is count==0.
- Reset asserted mid-operation: all state returns to reset values at the next edge. key_valid drops regardless of key_ready.

Decomposition:
- Package nios_keycode_pio_pkg: register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_IRQMASK=3) and STATUS/CONTROL/IRQMASK bit-position constants.
- Sub-module keycode_sync_fifo (DATA_W, DEPTH): storage, pointers, count, push/pop/flush, full/empty.
- The top level owns the bus decode, out_port, the registers and irq.

Test Plan:
- Reset, then write DATA=0x1C with key_ready=0 -> next cycle key_valid=1, key_data=0x1C, out_port=0x1C, STATUS count=1, empty=0.
- DEPTH=8, key_ready=0, write 0x01..0x09 -> count=8, full=1, 0x09 dropped, overflow=1, out_port=0x08. Then raise key_ready -> 0x01..0x08 drained in order, key_valid falls after 8 cycles.
- Full FIFO, write 0x55 in the same cycle as a pop -> no overflow, count stays 8, 0x55 emerges last.
- IRQMASK=0b01 with FIFO empty -> irq=1 one cycle after the write. Push one word -> irq=0 one cycle later. Write STATUS bit18 while overflow=1 -> overflow=0.
- Load 5 words, write CONTROL=0x3 -> next cycle count=0, key_valid=0, enable=1. A following write 0xAA appears at the head with pointers wrapped from 0.
- CONTROL=0, write DATA=0x77 -> no push, out_port unchanged. Then assert reset mid-drain -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/nios_keycode_fifo_pio_pkg.sv
// Register map and bit positions shared by the keycode FIFO PIO and its bus master.
package nios_keycode_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_IRQMASK = 2'd3;

    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 18;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int IRQ_EMPTY_BIT  = 0;
    localparam int IRQ_OVF_BIT    = 1;

    function automatic logic irq_level(input logic empty_ie, input logic empty,
                                       input logic ovf_ie, input logic ovf);
        return (empty_ie & empty) | (ovf_ie & ovf);
    endfunction

endpackage

// File: rtl/nios_keycode_fifo_pio_if.sv
// Avalon-MM slave bus plus the keycode valid/ready stream of the FIFO PIO.
interface nios_keycode_fifo_pio_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] key_data;
    logic              key_valid;
    logic              key_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, key_ready,
        output readdata, key_data, key_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, key_ready,
        input  readdata, key_data, key_valid
    );
endinterface

// File: rtl/nios_keycode_fifo_pio_fifo.sv
// Synchronous FIFO with occupancy counter and flush; head is masked to zero when empty.
module keycode_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nios_keycode_fifo_pio.sv
// Nios II keycode PIO: CPU writes are queued in a FIFO and drained over a valid/ready stream.
module nios_keycode_fifo_pio
    import nios_keycode_pio_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    nios_keycode_fifo_pio_if.slave   bus,
    output logic [DATA_W-1:0]        out_port,
    output logic                     irq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic             data_wr;
    logic             stat_wr;
    logic             ctrl_wr;
    logic             mask_wr;
    logic             push;
    logic             pop;
    logic             flush;
    logic             accept;
    logic             drop;
    logic             enable;
    logic             overflow;
    logic             empty_ie;
    logic             ovf_ie;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [31:0]      rd_word;

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign data_wr = wr_en & (bus.address == ADDR_DATA);
    assign stat_wr = wr_en & (bus.address == ADDR_STATUS);
    assign ctrl_wr = wr_en & (bus.address == ADDR_CTRL);
    assign mask_wr = wr_en & (bus.address == ADDR_IRQMASK);

    assign pop    = bus.key_valid & bus.key_ready;
    assign push   = data_wr & enable;
    assign flush  = ctrl_wr & bus.writedata[CTRL_FLUSH_BIT];
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    keycode_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (bus.writedata[DATA_W-1:0]),
        .rdata (bus.key_data),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign bus.key_valid = ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= '0;
            overflow <= 1'b0;
            enable   <= 1'b1;
            empty_ie <= 1'b0;
            ovf_ie   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (accept) begin
                out_port <= bus.writedata[DATA_W-1:0];
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (stat_wr && bus.writedata[STAT_OVF_BIT]) begin
                overflow <= 1'b0;
            end
            if (ctrl_wr) begin
                enable <= bus.writedata[CTRL_EN_BIT];
            end
            if (mask_wr) begin
                empty_ie <= bus.writedata[IRQ_EMPTY_BIT];
                ovf_ie   <= bus.writedata[IRQ_OVF_BIT];
            end
            irq <= irq_level(empty_ie, empty, ovf_ie, overflow);
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.address)
            ADDR_DATA: begin
                rd_word[DATA_W-1:0] = out_port;
            end
            ADDR_STATUS: begin
                rd_word[CNT_W-1:0]     = count;
                rd_word[STAT_EMPTY_BIT] = empty;
                rd_word[STAT_FULL_BIT]  = full;
                rd_word[STAT_OVF_BIT]   = overflow;
            end
            ADDR_CTRL: begin
                rd_word[CTRL_EN_BIT] = enable;
            end
            default: begin
                rd_word[IRQ_EMPTY_BIT] = empty_ie;
                rd_word[IRQ_OVF_BIT]   = ovf_ie;
            end
        endcase
    end

    assign bus.readdata = rd_word;

endmodule

// File: tb/tb_nios_keycode_fifo_pio.sv
// Directed bench for nios_keycode_fifo_pio with a scoreboard on the keycode stream.
module tb_nios_keycode_fifo_pio;

    logic       clk;
    logic       reset;
    logic [7:0] out_port;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];

    nios_keycode_fifo_pio_if #(.DATA_W(8)) bus ();

    nios_keycode_fifo_pio #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on the stream must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!reset && bus.key_valid && bus.key_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_pop: got 0x%0h expected no word", bus.key_data);
            end else begin
                check("stream_pop", {24'h0, bus.key_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic wr_pop(input logic [7:0] d);
        bus.address    = 2'd0;
        bus.writedata  = {24'h0, d};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.key_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.key_ready  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(posedge clk);
        #2;
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        check(name, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        bus.key_ready  = 1'b0;
        step(3);
        reset = 1'b0;

        // Reset state
        check("rst_key_valid", {31'h0, bus.key_valid}, 32'h0);
        check("rst_key_data", {24'h0, bus.key_data}, 32'h0);
        check("rst_out_port", {24'h0, out_port}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd(2'd1, 32'h0001_0000, "rst_status");
        rd(2'd2, 32'h1, "rst_ctrl");
        rd(2'd3, 32'h0, "rst_irqmask");
        rd(2'd0, 32'h0, "rst_data");

        // Single push, visible the next cycle
        sb.push_back(8'h1C);
        wr(2'd0, 32'h1C);
        check("push_key_valid", {31'h0, bus.key_valid}, 32'h1);
        check("push_key_data", {24'h0, bus.key_data}, 32'h1C);
        check("push_out_port", {24'h0, out_port}, 32'h1C);
        rd(2'd1, 32'h1, "push_status");
        bus.key_ready = 1'b1;
        step(1);
        bus.key_ready = 1'b0;
        check("pop1_key_valid", {31'h0, bus.key_valid}, 32'h0);

        // Fill past full: 0x09 is dropped
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) sb.push_back(8'(i));
            wr(2'd0, 32'(i));
        end
        rd(2'd1, 32'h0006_0008, "full_status");
        check("full_out_port", {24'h0, out_port}, 32'h08);
        check("full_head", {24'h0, bus.key_data}, 32'h01);

        // Push and pop together while full: no overflow
        wr(2'd1, 32'h0004_0000);
        rd(2'd1, 32'h0002_0008, "ovf_clear_status");
        sb.push_back(8'h55);
        wr_pop(8'h55);
        rd(2'd1, 32'h0002_0008, "full_pushpop_status");
        check("full_pushpop_out_port", {24'h0, out_port}, 32'h55);
        check("full_pushpop_head", {24'h0, bus.key_data}, 32'h02);

        // Drain 0x02..0x08, 0x55
        bus.key_ready = 1'b1;
        step(8);
        bus.key_ready = 1'b0;
        check("drain_key_valid", {31'h0, bus.key_valid}, 32'h0);
        rd(2'd1, 32'h0001_0000, "drain_status");

        // Empty interrupt
        wr(2'd3, 32'h1);
        step(1);
        check("irq_empty_set", {31'h0, irq}, 32'h1);
        sb.push_back(8'h33);
        wr(2'd0, 32'h33);
        step(1);
        check("irq_empty_clr", {31'h0, irq}, 32'h0);

        // Overflow interrupt and its clear
        wr(2'd3, 32'h2);
        for (int i = 0; i < 7; i++) begin
            sb.push_back(8'(8'h40 + i));
            wr(2'd0, 32'(8'h40 + i));
        end
        wr(2'd0, 32'h47);
        step(1);
        check("irq_ovf_set", {31'h0, irq}, 32'h1);
        rd(2'd1, 32'h0006_0008, "ovf_status");
        wr(2'd1, 32'h0004_0000);
        step(1);
        check("irq_ovf_clr", {31'h0, irq}, 32'h0);
        rd(2'd1, 32'h0002_0008, "ovf_cleared_status");
        wr(2'd3, 32'h0);
        bus.key_ready = 1'b1;
        step(8);
        bus.key_ready = 1'b0;

        // Flush with enable kept
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(8'(8'hA0 + i));
            wr(2'd0, 32'(8'hA0 + i));
        end
        rd(2'd1, 32'h5, "preflush_status");
        wr(2'd2, 32'h3);
        sb.delete();
        check("flush_key_valid", {31'h0, bus.key_valid}, 32'h0);
        check("flush_out_port", {24'h0, out_port}, 32'hA5);
        rd(2'd1, 32'h0001_0000, "flush_status");
        rd(2'd2, 32'h1, "flush_ctrl");
        sb.push_back(8'hAA);
        wr(2'd0, 32'hAA);
        check("postflush_head", {24'h0, bus.key_data}, 32'hAA);
        rd(2'd1, 32'h1, "postflush_status");
        bus.key_ready = 1'b1;
        step(1);
        bus.key_ready = 1'b0;

        // Disabled writes are ignored
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h0, "disable_ctrl");
        wr(2'd0, 32'h77);
        check("disabled_out_port", {24'h0, out_port}, 32'hAA);
        check("disabled_key_valid", {31'h0, bus.key_valid}, 32'h0);
        rd(2'd1, 32'h0001_0000, "disabled_status");
        wr(2'd2, 32'h1);

        // Reset in the middle of a drain
        wr(2'd3, 32'h3);
        sb.push_back(8'h11);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        wr(2'd0, 32'h33);
        bus.key_ready = 1'b1;
        step(1);
        reset = 1'b1;
        sb.delete();
        step(1);
        check("midrst_key_valid", {31'h0, bus.key_valid}, 32'h0);
        check("midrst_key_data", {24'h0, bus.key_data}, 32'h0);
        check("midrst_out_port", {24'h0, out_port}, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        bus.key_ready = 1'b0;
        rd(2'd1, 32'h0001_0000, "midrst_status");
        rd(2'd2, 32'h1, "midrst_ctrl");
        rd(2'd3, 32'h0, "midrst_irqmask");

        check("sb_remaining", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
